// File: rtl/fifo_read_port.sv
// fifo_read_port
//   Read-side controller of an asynchronous FIFO, entirely in the clk_1 domain.
//   Synchronizes the Gray write pointer, derives empty/occupancy, fetches words
//   from port 1 of the dual-port RAM into a registered first-word-fall-through
//   output stage, and returns the Gray read pointer to the write side.
//
//   Ports
//     clk_1, rst_1          read clock, synchronous active-high reset
//     wptr_gray             Gray write pointer from the write domain (async)
//     rptr_gray             registered Gray read pointer to the write domain
//     addr_1, we_1, oe_1    RAM port 1 controls (we_1 tied low)
//     data_1                RAM port 1 read data, combinational from addr_1
//     rd_data, rd_valid     registered word and its valid flag
//     rd_ready              consumer accept
//     empty                 nothing in RAM and nothing in the output register
//     ram_count             words in RAM not yet loaded (0..2^ADDR_WIDTH)
//
//   Output state machine
//     state    | meaning
//     ST_EMPTY | output register holds no word (rd_valid = 0)
//     ST_FULL  | output register holds an unconsumed word (rd_valid = 1)
module fifo_read_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_1,
  input  logic                  rst_1,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic                  we_1,
  output logic                  oe_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   ram_count
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         sync_a_q, sync_b_q;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]         wbin_s;
  logic                  ram_empty;
  logic                  load;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(sync_b_q >> i);
    end
  end

  // The registered Gray read pointer always equals Gray(rbin_q), so comparing
  // two Gray codes avoids converting the read side back to binary.
  assign ram_empty = (rptr_gray_q == sync_b_q);
  assign rd_valid  = (state_q == ST_FULL);
  assign load      = !ram_empty && (!rd_valid || rd_ready);

  // State register
  always_ff @(posedge clk_1) begin
    if (rst_1) begin
      state_q     <= ST_EMPTY;
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync_a_q    <= wptr_gray;
      sync_b_q    <= sync_a_q;
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (rd_ready && ram_empty) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    rbin_d      = rbin_q;
    rd_data_d   = rd_data_q;
    if (load) begin
      rbin_d    = rbin_q + 1'b1;
      rd_data_d = data_1;
    end
    // Gray is taken from the next binary value so the pointer seen by the
    // write domain changes by exactly one bit per load and never glitches.
    rptr_gray_d = rbin_d ^ (rbin_d >> 1);
  end

  assign oe_1      = load;
  assign we_1      = 1'b0;
  assign addr_1    = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray = rptr_gray_q;
  assign rd_data   = rd_data_q;
  assign empty     = !rd_valid && ram_empty;
  assign ram_count = wbin_s - rbin_q;

endmodule

// File: tb/tb_fifo_read_port.sv
module tb_fifo_read_port;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk_1 = 1'b0;
  logic          rst_1;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] addr_1;
  logic          we_1;
  logic          oe_1;
  logic [DW-1:0] data_1;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          empty;
  logic [AW:0]   ram_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_1 = ~clk_1;

  assign data_1 = mem[addr_1];

  fifo_read_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_1     (clk_1),
    .rst_1     (rst_1),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .addr_1    (addr_1),
    .we_1      (we_1),
    .oe_1      (oe_1),
    .data_1    (data_1),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .empty     (empty),
    .ram_count (ram_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    rst_1     = 1'b1;
    wptr_gray = '0;
    tick();
    tick();
    rst_1 = 1'b0;
  endtask

  int wr_cnt, rd_cnt, wbin, cyc;
  logic acc;

  initial begin
    rst_1     = 1'b1;
    wptr_gray = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

    // Reset values
    do_reset();
    chk("rst_rptr",  32'(rptr_gray), 32'h0);
    chk("rst_addr",  32'(addr_1),    32'h0);
    chk("rst_we",    32'(we_1),      32'h0);
    chk("rst_oe",    32'(oe_1),      32'h0);
    chk("rst_data",  32'(rd_data),   32'h0);
    chk("rst_valid", 32'(rd_valid),  32'h0);
    chk("rst_empty", 32'(empty),     32'h1);
    chk("rst_count", 32'(ram_count), 32'h0);

    // Single word: valid appears on the third edge after the pointer change
    mem[0]    = 8'hA5;
    wptr_gray = gray(1);
    tick();
    chk("sw_e0_valid", 32'(rd_valid),  32'h0);
    chk("sw_e0_count", 32'(ram_count), 32'h0);
    tick();
    chk("sw_e1_valid", 32'(rd_valid),  32'h0);
    chk("sw_e1_count", 32'(ram_count), 32'h1);
    chk("sw_e1_oe",    32'(oe_1),      32'h1);
    tick();
    chk("sw_e2_valid", 32'(rd_valid),  32'h1);
    chk("sw_e2_data",  32'(rd_data),   32'hA5);
    chk("sw_e2_count", 32'(ram_count), 32'h0);
    chk("sw_e2_rptr",  32'(rptr_gray), 32'h1);
    chk("sw_e2_empty", 32'(empty),     32'h0);
    rd_ready = 1'b1;
    tick();
    chk("sw_acc_valid", 32'(rd_valid), 32'h0);
    chk("sw_acc_empty", 32'(empty),    32'h1);
    rd_ready = 1'b0;

    // Full burst of 16 words from a fresh pointer
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    rd_ready  = 1'b1;
    wptr_gray = 5'h18;
    tick();
    tick();
    chk("fb_peak_count", 32'(ram_count), 32'd16);
    chk("fb_pre_valid",  32'(rd_valid),  32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("fb_valid", 32'(rd_valid), 32'h1);
      chk("fb_data",  32'(rd_data),  32'(8'h10 + k));
    end
    tick();
    chk("fb_end_valid", 32'(rd_valid),  32'h0);
    chk("fb_end_empty", 32'(empty),     32'h1);
    chk("fb_end_rptr",  32'(rptr_gray), 32'h18);
    chk("fb_end_count", 32'(ram_count), 32'h0);
    rd_ready = 1'b0;

    // Backpressure: read pointer at 16, three words pending
    mem[0]    = 8'h31;
    mem[1]    = 8'h32;
    mem[2]    = 8'h33;
    wptr_gray = gray(19);
    tick();
    tick();
    tick();
    chk("bp_valid", 32'(rd_valid),  32'h1);
    chk("bp_data",  32'(rd_data),   32'h31);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_data",  32'(rd_data),   32'h31);
      chk("bp_hold_oe",    32'(oe_1),      32'h0);
      chk("bp_hold_count", 32'(ram_count), 32'h2);
      chk("bp_hold_addr",  32'(addr_1),    32'h1);
      chk("bp_hold_rptr",  32'(rptr_gray), 32'(gray(17)));
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("bp_rel_data1", 32'(rd_data), 32'h32);
    tick();
    chk("bp_rel_data2", 32'(rd_data), 32'h33);
    tick();
    chk("bp_rel_valid", 32'(rd_valid), 32'h0);
    rd_ready = 1'b0;

    // Wrap-around: 40 words streamed with a ready pattern, pointer from 19
    wbin   = 19;
    wr_cnt = 0;
    rd_cnt = 0;
    cyc    = 0;
    while (rd_cnt < 40 && cyc < 400) begin
      if (wr_cnt < 40 && (wr_cnt - rd_cnt) < 16 && (cyc % 5) != 4) begin
        mem[wbin % 16] = 8'(8'h40 + wr_cnt);
        wbin++;
        wr_cnt++;
        wptr_gray = gray(wbin);
      end
      rd_ready = ((cyc % 3) != 2);
      acc = rd_valid && rd_ready;
      tick();
      if (acc) rd_cnt++;
      if (rd_valid) begin
        chk("wr_data",        32'(rd_data), 32'(8'h40 + rd_cnt));
        chk("wr_valid_avail", 32'(rd_cnt < wr_cnt), 32'h1);
      end
      cyc++;
    end
    chk("wr_all_read", 32'(rd_cnt), 32'd40);
    rd_ready = 1'b0;
    tick();
    chk("wr_end_rptr",  32'(rptr_gray), 32'(gray(59)));
    chk("wr_end_empty", 32'(empty),     32'h1);
    chk("wr_end_count", 32'(ram_count), 32'h0);

    // Reset mid-burst with 8 words pending
    for (int k = 0; k < 8; k++) mem[(59 + k) % 16] = 8'(8'h70 + k);
    wptr_gray = gray(67);
    tick();
    tick();
    tick();
    chk("rm_valid", 32'(rd_valid), 32'h1);
    chk("rm_data",  32'(rd_data),  32'h70);
    chk("rm_count", 32'(ram_count), 32'h7);
    rst_1 = 1'b1;
    tick();
    chk("rm_rst_valid", 32'(rd_valid),  32'h0);
    chk("rm_rst_rptr",  32'(rptr_gray), 32'h0);
    chk("rm_rst_data",  32'(rd_data),   32'h0);
    wptr_gray = '0;
    tick();
    rst_1 = 1'b0;
    tick();
    tick();
    chk("rm_post_empty", 32'(empty),     32'h1);
    chk("rm_post_count", 32'(ram_count), 32'h0);
    chk("rm_post_valid", 32'(rd_valid),  32'h0);
    chk("rm_post_addr",  32'(addr_1),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
